// File: rtl/wait_event_if.sv
// Decoder <-> wait_event bundle: command inputs, watched signals, status outputs.
// Latency: none, wires only.
// Backpressure: none; o_wait_done is the decoder's acknowledge for the held i_sel_wait level.
interface wait_event_if #(
    parameter int WAIT_SIGNALS_NB = 8,
    parameter int TIMEOUT_WIDTH   = 32
);
    localparam int IDX_W = (WAIT_SIGNALS_NB > 1) ? $clog2(WAIT_SIGNALS_NB) : 1;

    logic                       i_sel_wait;
    logic                       i_edge_falling;
    logic [IDX_W-1:0]           i_sig_index;
    logic [TIMEOUT_WIDTH-1:0]   i_timeout;
    logic [WAIT_SIGNALS_NB-1:0] i_wait_signals;
    logic                       o_wait_done;
    logic                       o_timeout;
    logic                       o_busy;
    logic [TIMEOUT_WIDTH-1:0]   o_elapsed;

    // Decoder / testbench side
    modport master (
        output i_sel_wait, i_edge_falling, i_sig_index, i_timeout, i_wait_signals,
        input  o_wait_done, o_timeout, o_busy, o_elapsed
    );

    // Wait unit side
    modport slave (
        input  i_sel_wait, i_edge_falling, i_sig_index, i_timeout, i_wait_signals,
        output o_wait_done, o_timeout, o_busy, o_elapsed
    );
endinterface

// File: rtl/wait_event.sv
// Waits for a rising/falling edge on one selected signal, bounded by an optional cycle timeout.
// Latency: busy 1 clk after start; done 1 clk after the sampled edge or N edges after start on timeout.
// Backpressure: o_wait_done holds until the decoder drops i_sel_wait; new starts only from IDLE.
module wait_event #(
    parameter int WAIT_SIGNALS_NB = 8,
    parameter int TIMEOUT_WIDTH   = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    wait_event_if.slave  bus
);
    localparam int IDX_W = (WAIT_SIGNALS_NB > 1) ? $clog2(WAIT_SIGNALS_NB) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                   state, state_nxt;
    logic                     sel_q;
    logic                     falling_q, falling_nxt;
    logic [IDX_W-1:0]         idx_q, idx_nxt;
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_nxt;
    logic                     prev_q, prev_nxt;
    logic                     done_q, done_nxt;
    logic                     tflag_q, tflag_nxt;
    logic                     busy_q, busy_nxt;
    logic [TIMEOUT_WIDTH-1:0] elapsed_q, elapsed_nxt;

    logic                     start;
    logic                     bad_index;
    logic                     start_bit;
    logic                     cur;
    logic                     hit;
    logic [TIMEOUT_WIDTH-1:0] elapsed_inc;

    assign start     = bus.i_sel_wait & ~sel_q;
    assign bad_index = int'(bus.i_sig_index) >= WAIT_SIGNALS_NB;

    // Mux out the watched bit for the incoming index (start) and the latched index (wait);
    // an out-of-range index reads as 0 rather than X.
    always_comb begin
        start_bit = 1'b0;
        cur       = 1'b0;
        for (int i = 0; i < WAIT_SIGNALS_NB; i++) begin
            if (bus.i_sig_index == IDX_W'(i)) start_bit = bus.i_wait_signals[i];
            if (idx_q == IDX_W'(i))           cur       = bus.i_wait_signals[i];
        end
    end

    assign hit         = falling_q ? (~cur & prev_q) : (cur & ~prev_q);
    assign elapsed_inc = (elapsed_q == '1) ? elapsed_q : elapsed_q + TIMEOUT_WIDTH'(1);

    // Next-state and next-output logic; every register defaults to holding its value.
    always_comb begin
        state_nxt   = state;
        falling_nxt = falling_q;
        idx_nxt     = idx_q;
        tmo_nxt     = tmo_q;
        prev_nxt    = prev_q;
        done_nxt    = done_q;
        tflag_nxt   = tflag_q;
        busy_nxt    = busy_q;
        elapsed_nxt = elapsed_q;
        case (state)
            IDLE: begin
                if (start) begin
                    falling_nxt = bus.i_edge_falling;
                    idx_nxt     = bus.i_sig_index;
                    tmo_nxt     = bus.i_timeout;
                    prev_nxt    = start_bit;
                    tflag_nxt   = 1'b0;
                    elapsed_nxt = '0;
                    if (bad_index) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        tflag_nxt = 1'b1;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt = WAIT;
                        busy_nxt  = 1'b1;
                    end
                end
            end
            WAIT: begin
                prev_nxt = cur;
                if (!bus.i_sel_wait) begin
                    // Abort: back to idle silently, elapsed keeps the partial count.
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b0;
                    tflag_nxt = 1'b0;
                end else if (hit) begin
                    // A hit beats a timeout landing on the same edge.
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end else begin
                    elapsed_nxt = elapsed_inc;
                    if (tmo_q != '0 && elapsed_inc == tmo_q) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        tflag_nxt = 1'b1;
                        busy_nxt  = 1'b0;
                    end
                end
            end
            DONE: begin
                if (!bus.i_sel_wait) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel_q     <= 1'b0;
            falling_q <= 1'b0;
            idx_q     <= '0;
            tmo_q     <= '0;
            prev_q    <= 1'b0;
            done_q    <= 1'b0;
            tflag_q   <= 1'b0;
            busy_q    <= 1'b0;
            elapsed_q <= '0;
        end else begin
            state     <= state_nxt;
            sel_q     <= bus.i_sel_wait;
            falling_q <= falling_nxt;
            idx_q     <= idx_nxt;
            tmo_q     <= tmo_nxt;
            prev_q    <= prev_nxt;
            done_q    <= done_nxt;
            tflag_q   <= tflag_nxt;
            busy_q    <= busy_nxt;
            elapsed_q <= elapsed_nxt;
        end
    end

    assign bus.o_wait_done = done_q;
    assign bus.o_timeout   = tflag_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_elapsed   = elapsed_q;
endmodule

// File: tb/tb_wait_event.sv
// Directed bench for wait_event with 6 watched signals so index 6 is representable and out of range.
// Latency: inputs driven and outputs checked 1 time unit after each rising clk edge.
// Backpressure: bench holds i_sel_wait for each command and drops it to release done.
module tb_wait_event;
    localparam int NB = 6;
    localparam int TW = 32;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    wait_event_if #(.WAIT_SIGNALS_NB(NB), .TIMEOUT_WIDTH(TW)) bus ();

    wait_event #(.WAIT_SIGNALS_NB(NB), .TIMEOUT_WIDTH(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic done, input logic tmo,
                             input logic busy, input logic [31:0] el);
        check({tag, ".done"},    32'(bus.o_wait_done), 32'(done));
        check({tag, ".timeout"}, 32'(bus.o_timeout),   32'(tmo));
        check({tag, ".busy"},    32'(bus.o_busy),      32'(busy));
        check({tag, ".elapsed"}, bus.o_elapsed,        el);
    endtask

    task automatic cmd(input logic falling, input logic [2:0] idx, input logic [31:0] tmo);
        bus.i_edge_falling = falling;
        bus.i_sig_index    = idx;
        bus.i_timeout      = tmo;
        bus.i_sel_wait     = 1'b1;
    endtask

    // Directed sequence
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n              = 1'b0;
        bus.i_sel_wait     = 1'b0;
        bus.i_edge_falling = 1'b0;
        bus.i_sig_index    = '0;
        bus.i_timeout      = '0;
        bus.i_wait_signals = '0;
        #12;
        check_out("reset", 1'b0, 1'b0, 1'b0, 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // WTR idx 3, no timeout, edge arrives before the 5th edge after start
        cmd(1'b0, 3'd3, 0);
        tick(1);
        check_out("wtr.start", 1'b0, 1'b0, 1'b1, 0);
        tick(4);
        check_out("wtr.waiting", 1'b0, 1'b0, 1'b1, 4);
        bus.i_wait_signals[3] = 1'b1;
        tick(1);
        check_out("wtr.hit", 1'b1, 1'b0, 1'b0, 4);
        tick(2);
        check_out("wtr.hold", 1'b1, 1'b0, 1'b0, 4);
        bus.i_sel_wait = 1'b0;
        bus.i_wait_signals[3] = 1'b0;
        tick(1);
        check_out("wtr.release", 1'b0, 1'b0, 1'b0, 4);

        // WTF idx 0, signal held low, timeout 10
        cmd(1'b1, 3'd0, 10);
        tick(1);
        tick(9);
        check_out("wtf.pre_tmo", 1'b0, 1'b0, 1'b1, 9);
        tick(1);
        check_out("wtf.tmo", 1'b1, 1'b1, 1'b0, 10);
        bus.i_sel_wait = 1'b0;
        tick(1);
        check_out("wtf.release", 1'b0, 1'b1, 1'b0, 10);

        // Timeout 3 with the edge on the 3rd wait edge: the hit wins
        cmd(1'b0, 3'd1, 3);
        tick(3);
        bus.i_wait_signals[1] = 1'b1;
        tick(1);
        check_out("race.hit_wins", 1'b1, 1'b0, 1'b0, 2);
        bus.i_sel_wait = 1'b0;
        tick(1);
        bus.i_wait_signals[1] = 1'b0;

        // Signal already high at WTR start: its level is not an edge
        bus.i_wait_signals[2] = 1'b1;
        cmd(1'b0, 3'd2, 0);
        tick(4);
        check_out("prehigh.no_hit", 1'b0, 1'b0, 1'b1, 3);
        bus.i_wait_signals[2] = 1'b0;
        tick(1);
        check_out("prehigh.fall", 1'b0, 1'b0, 1'b1, 4);
        bus.i_wait_signals[2] = 1'b1;
        tick(1);
        check_out("prehigh.rise", 1'b1, 1'b0, 1'b0, 4);
        bus.i_sel_wait = 1'b0;
        tick(1);
        bus.i_wait_signals[2] = 1'b0;

        // Index == number of signals: immediate done with timeout flag
        cmd(1'b0, 3'd6, 0);
        tick(1);
        check_out("badidx", 1'b1, 1'b1, 1'b0, 0);
        bus.i_sel_wait = 1'b0;
        tick(1);
        check_out("badidx.release", 1'b0, 1'b1, 1'b0, 0);

        // Abort after 4 wait edges, restart one cycle later
        cmd(1'b0, 3'd4, 0);
        tick(1);
        check_out("abort.start", 1'b0, 1'b0, 1'b1, 0);
        tick(4);
        bus.i_sel_wait = 1'b0;
        tick(1);
        check_out("abort.idle", 1'b0, 1'b0, 1'b0, 4);
        bus.i_sel_wait = 1'b1;
        tick(1);
        check_out("abort.restart", 1'b0, 1'b0, 1'b1, 0);
        tick(2);
        check_out("abort.running", 1'b0, 1'b0, 1'b1, 2);

        // Reset mid-wait clears outputs without waiting for a clock
        #1;
        rst_n = 1'b0;
        bus.i_sel_wait = 1'b0;
        #1;
        check_out("rst.async", 1'b0, 1'b0, 1'b0, 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        cmd(1'b0, 3'd5, 0);
        tick(1);
        check_out("rst.fresh_start", 1'b0, 1'b0, 1'b1, 0);
        tick(1);
        bus.i_wait_signals[5] = 1'b1;
        tick(1);
        check_out("rst.fresh_hit", 1'b1, 1'b0, 1'b0, 1);
        bus.i_sel_wait = 1'b0;
        tick(1);
        check_out("rst.fresh_release", 1'b0, 1'b0, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
